// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the memory-game controller: state encoding and
// the control word that the FSM drives into the datapath.
package game_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_INIT   = 3'd0,
        S_SETUP  = 3'd1,
        S_SEQ    = 3'd2,
        S_PLAY   = 3'd3,
        S_CHECK  = 3'd4,
        S_NEXT   = 3'd5,
        S_CLEAR  = 3'd6,
        S_RESULT = 3'd7
    } state_t;

    typedef struct packed {
        logic r1;
        logic r2;
        logic e1;
        logic e2;
        logic e3;
        logic e4;
        logic sel;
    } ctrl_t;

    // Control word for a given state; sel defaults to the game view.
    function automatic ctrl_t decode_state(state_t s);
        ctrl_t c;
        c     = '0;
        c.sel = 1'b1;
        case (s)
            S_INIT:   begin c.r1 = 1'b1; c.r2 = 1'b1; end
            S_SETUP:  c.e1 = 1'b1;
            S_SEQ:    c.e3 = 1'b1;
            S_PLAY:   c.e2 = 1'b1;
            S_CHECK:  ;
            S_NEXT:   c.e4 = 1'b1;
            S_CLEAR:  c.r2 = 1'b1;
            S_RESULT: c.sel = 1'b0;
            default:  begin c.r1 = 1'b1; c.r2 = 1'b1; end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/game_controller_enter_sync.sv
// Enter key conditioning: polarity fix, two-flop synchronizer and a
// registered rising-edge detector producing a single-cycle press pulse.
// Reset parks every flop at the released level so no pulse follows reset.
module enter_sync #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    logic level;
    logic sync1;
    logic sync2;
    logic prev;
    logic pulse_q;

    // Normalise so that 1 always means "pressed" before synchronizing.
    assign level = ACTIVE_LOW ? ~key : key;

    // Synchronize the raw key and register the press edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prev    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1   <= level;
            sync2   <= sync1;
            prev    <= sync2;
            pulse_q <= sync2 & ~prev;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/game_controller.sv
// Moore controller sequencing the memory-game datapath. Outputs come from
// a register updated together with the state, so no input reaches an
// output combinationally. dbg_state mirrors the registered state.
module game_controller
    import game_ctrl_pkg::*;
#(
    parameter bit ENTER_ACTIVE_LOW = 1'b1,
    parameter int R2_HOLD          = 4,
    parameter int STATE_W          = game_ctrl_pkg::STATE_W
) (
    input  logic               clock_50,
    input  logic               reset,
    input  logic               enter,
    input  logic               end_fpga,
    input  logic               end_user,
    input  logic               end_time,
    input  logic               win,
    input  logic               match,
    output logic               r1,
    output logic               r2,
    output logic               e1,
    output logic               e2,
    output logic               e3,
    output logic               e4,
    output logic               sel,
    output logic [STATE_W-1:0] dbg_state
);

    localparam int              HOLD_W    = (R2_HOLD > 1) ? $clog2(R2_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(R2_HOLD - 1);

    state_t            state;
    ctrl_t             ctrl;
    logic [HOLD_W-1:0] hold_cnt;
    logic              enter_p;

    enter_sync #(
        .ACTIVE_LOW (ENTER_ACTIVE_LOW)
    ) u_enter_sync (
        .clk   (clock_50),
        .rst   (reset),
        .key   (enter),
        .pulse (enter_p)
    );

    // State, CLEAR hold counter and registered control word; every move
    // loads the control word of the destination state in the same edge.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state    <= S_INIT;
            ctrl     <= decode_state(S_INIT);
            hold_cnt <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    state <= S_SETUP;
                    ctrl  <= decode_state(S_SETUP);
                end
                S_SETUP: begin
                    if (enter_p) begin
                        state <= S_SEQ;
                        ctrl  <= decode_state(S_SEQ);
                    end
                end
                S_SEQ: begin
                    if (end_fpga) begin
                        state <= S_PLAY;
                        ctrl  <= decode_state(S_PLAY);
                    end
                end
                S_PLAY: begin
                    // A timeout is a loss even if the user just finished.
                    if (end_time) begin
                        state <= S_RESULT;
                        ctrl  <= decode_state(S_RESULT);
                    end else if (end_user) begin
                        state <= S_CHECK;
                        ctrl  <= decode_state(S_CHECK);
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        state <= S_NEXT;
                        ctrl  <= decode_state(S_NEXT);
                    end else begin
                        state <= S_RESULT;
                        ctrl  <= decode_state(S_RESULT);
                    end
                end
                S_NEXT: begin
                    // win reflects the round before the e4 increment lands.
                    if (win) begin
                        state <= S_RESULT;
                        ctrl  <= decode_state(S_RESULT);
                    end else begin
                        state    <= S_CLEAR;
                        ctrl     <= decode_state(S_CLEAR);
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                S_CLEAR: begin
                    // r2 is held long enough for slow-clocked round logic.
                    if (hold_cnt == '0) begin
                        state <= S_SEQ;
                        ctrl  <= decode_state(S_SEQ);
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_RESULT: begin
                    if (enter_p) begin
                        state <= S_INIT;
                        ctrl  <= decode_state(S_INIT);
                    end
                end
                default: begin
                    state <= S_INIT;
                    ctrl  <= decode_state(S_INIT);
                end
            endcase
        end
    end

    assign r1        = ctrl.r1;
    assign r2        = ctrl.r2;
    assign e1        = ctrl.e1;
    assign e2        = ctrl.e2;
    assign e3        = ctrl.e3;
    assign e4        = ctrl.e4;
    assign sel       = ctrl.sel;
    assign dbg_state = STATE_W'(state);

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller. Two instances share the datapath stimulus:
// dut_a uses an active-low key with R2_HOLD=4, dut_b an active-high key
// with R2_HOLD=1.
module tb_game_controller;

    logic clock_50 = 1'b0;
    logic reset;
    logic key;
    logic enter_a;
    logic enter_b;
    logic end_fpga;
    logic end_user;
    logic end_time;
    logic win;
    logic match;

    logic       r1_a, r2_a, e1_a, e2_a, e3_a, e4_a, sel_a;
    logic       r1_b, r2_b, e1_b, e2_b, e3_b, e4_b, sel_b;
    logic [2:0] dbg_a;
    logic [2:0] dbg_b;

    int n_checks = 0;
    int n_errors = 0;

    assign enter_a = ~key;
    assign enter_b = key;

    // Clock and reset
    always #5 clock_50 = ~clock_50;

    game_controller #(
        .ENTER_ACTIVE_LOW (1'b1),
        .R2_HOLD          (4),
        .STATE_W          (3)
    ) dut_a (
        .clock_50  (clock_50),
        .reset     (reset),
        .enter     (enter_a),
        .end_fpga  (end_fpga),
        .end_user  (end_user),
        .end_time  (end_time),
        .win       (win),
        .match     (match),
        .r1        (r1_a),
        .r2        (r2_a),
        .e1        (e1_a),
        .e2        (e2_a),
        .e3        (e3_a),
        .e4        (e4_a),
        .sel       (sel_a),
        .dbg_state (dbg_a)
    );

    game_controller #(
        .ENTER_ACTIVE_LOW (1'b0),
        .R2_HOLD          (1),
        .STATE_W          (3)
    ) dut_b (
        .clock_50  (clock_50),
        .reset     (reset),
        .enter     (enter_b),
        .end_fpga  (end_fpga),
        .end_user  (end_user),
        .end_time  (end_time),
        .win       (win),
        .match     (match),
        .r1        (r1_b),
        .r2        (r2_b),
        .e1        (e1_b),
        .e2        (e2_b),
        .e3        (e3_b),
        .e4        (e4_b),
        .sel       (sel_b),
        .dbg_state (dbg_b)
    );

    logic [6:0] outs_a;
    logic [6:0] outs_b;
    assign outs_a = {r1_a, r2_a, e1_a, e2_a, e3_a, e4_a, sel_a};
    assign outs_b = {r1_b, r2_b, e1_b, e2_b, e3_b, e4_b, sel_b};

    // Required control word {r1,r2,e1,e2,e3,e4,sel} for each state number.
    function automatic logic [6:0] want_outs(int s);
        case (s)
            0:       return 7'b1100001;
            1:       return 7'b0010001;
            2:       return 7'b0000101;
            3:       return 7'b0001001;
            4:       return 7'b0000001;
            5:       return 7'b0000011;
            6:       return 7'b0100001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic k, input logic f, input logic u,
                              input logic t, input logic w, input logic m);
        key      = k;
        end_fpga = f;
        end_user = u;
        end_time = t;
        win      = w;
        match    = m;
    endtask

    // Directed vector table: inputs applied for one edge, expected states after it.
    typedef struct {
        logic k, f, u, t, w, m;
        int   exp_a;
        int   exp_b;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic k, input logic f, input logic u, input logic t,
                       input logic w, input logic m, input int ea, input int eb);
        vec_t v;
        v.k = k; v.f = f; v.u = u; v.t = t; v.w = w; v.m = m;
        v.exp_a = ea;
        v.exp_b = eb;
        vecs.push_back(v);
    endtask

    // Reference model: game rules stated directly on numbered phases.
    int m_state[2];
    int m_clear_elapsed[2];
    int hold_of[2] = '{4, 1};
    bit key_hist[4];
    logic [9:0] exp_q[$];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d]         = 0;
            m_clear_elapsed[d] = 0;
        end
        for (int i = 0; i < 4; i++) key_hist[i] = 1'b0;
    endtask

    task automatic model_step();
        // A press counts once, three edges after it is first seen held.
        bit press;
        int ns;
        press = key_hist[2] & ~key_hist[3];
        for (int d = 0; d < 2; d++) begin
            ns = m_state[d];
            case (m_state[d])
                0: ns = 1;
                1: if (press) ns = 2;
                2: if (end_fpga) ns = 2 + 1;
                3: begin
                    if (end_time)      ns = 7;
                    else if (end_user) ns = 4;
                end
                4: ns = match ? 5 : 7;
                5: begin
                    if (win) ns = 7;
                    else begin
                        ns = 6;
                        m_clear_elapsed[d] = 1;
                    end
                end
                6: begin
                    if (m_clear_elapsed[d] >= hold_of[d]) ns = 2;
                    else m_clear_elapsed[d] = m_clear_elapsed[d] + 1;
                end
                default: if (press) ns = 0;
            endcase
            m_state[d] = ns;
        end
        key_hist[3] = key_hist[2];
        key_hist[2] = key_hist[1];
        key_hist[1] = key_hist[0];
        key_hist[0] = key;
    endtask

    initial begin
        logic [9:0] exp_v;

        // Reset state
        reset = 1'b1;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset_state_a", dbg_a, 0);
        check("reset_outs_a", outs_a, 7'b1100001);
        check("reset_state_b", dbg_b, 0);
        check("reset_outs_b", outs_b, 7'b1100001);
        repeat (2) @(negedge clock_50);

        //   k  f  u  t  w  m   a  b
        add(0, 0, 0, 0, 0, 0,  1, 1);
        add(1, 0, 0, 0, 0, 0,  1, 1);
        add(1, 0, 0, 0, 0, 0,  1, 1);
        add(1, 0, 0, 0, 0, 0,  1, 1);
        add(1, 0, 0, 0, 0, 0,  2, 2);
        add(1, 0, 0, 0, 0, 0,  2, 2);
        add(1, 1, 0, 0, 0, 0,  3, 3);
        add(1, 0, 0, 0, 0, 0,  3, 3);
        add(0, 0, 1, 0, 0, 1,  4, 4);
        add(0, 0, 0, 0, 0, 1,  5, 5);
        add(0, 0, 0, 0, 0, 0,  6, 6);
        add(0, 0, 0, 0, 0, 0,  6, 2);
        add(0, 0, 0, 0, 0, 0,  6, 2);
        add(0, 0, 0, 0, 0, 0,  6, 2);
        add(0, 0, 0, 0, 0, 0,  2, 2);
        add(0, 1, 0, 0, 0, 0,  3, 3);
        add(0, 0, 1, 0, 0, 0,  4, 4);
        add(0, 0, 0, 0, 0, 0,  7, 7);
        add(1, 0, 0, 0, 0, 0,  7, 7);
        add(1, 0, 0, 0, 0, 0,  7, 7);
        add(1, 0, 0, 0, 0, 0,  7, 7);
        add(1, 0, 0, 0, 0, 0,  0, 0);
        add(0, 0, 0, 0, 0, 0,  1, 1);
        add(1, 0, 0, 0, 0, 0,  1, 1);
        add(0, 0, 0, 0, 0, 0,  1, 1);
        add(0, 0, 0, 0, 0, 0,  1, 1);
        add(0, 0, 0, 0, 0, 0,  2, 2);
        add(0, 1, 0, 0, 0, 0,  3, 3);
        add(0, 0, 1, 1, 0, 1,  7, 7);
        add(0, 0, 0, 0, 0, 0,  7, 7);
        add(1, 0, 0, 0, 0, 0,  7, 7);
        add(0, 0, 0, 0, 0, 0,  7, 7);
        add(0, 0, 0, 0, 0, 0,  7, 7);
        add(0, 0, 0, 0, 0, 0,  0, 0);
        add(0, 0, 0, 0, 0, 0,  1, 1);
        add(1, 0, 0, 0, 0, 0,  1, 1);
        add(0, 0, 0, 0, 0, 0,  1, 1);
        add(0, 0, 0, 0, 0, 0,  1, 1);
        add(0, 0, 0, 0, 0, 0,  2, 2);
        add(0, 1, 0, 0, 0, 0,  3, 3);
        add(0, 0, 1, 0, 0, 1,  4, 4);
        add(0, 0, 0, 0, 0, 1,  5, 5);
        add(0, 0, 0, 0, 1, 0,  7, 7);
        add(0, 0, 0, 0, 0, 0,  7, 7);
        add(1, 0, 0, 0, 0, 0,  7, 7);
        add(0, 0, 0, 0, 0, 0,  7, 7);
        add(0, 0, 0, 0, 0, 0,  7, 7);
        add(0, 0, 0, 0, 0, 0,  0, 0);
        add(0, 0, 0, 0, 0, 0,  1, 1);
        add(1, 0, 0, 0, 0, 0,  1, 1);
        add(0, 0, 0, 0, 0, 0,  1, 1);
        add(0, 0, 0, 0, 0, 0,  1, 1);
        add(0, 0, 0, 0, 0, 0,  2, 2);
        add(0, 1, 0, 0, 0, 0,  3, 3);
        add(0, 0, 0, 0, 0, 0,  3, 3);

        reset = 1'b0;
        foreach (vecs[i]) begin
            set_inputs(vecs[i].k, vecs[i].f, vecs[i].u, vecs[i].t, vecs[i].w, vecs[i].m);
            @(posedge clock_50);
            #1;
            check($sformatf("row%0d_state_a", i), dbg_a, vecs[i].exp_a);
            check($sformatf("row%0d_outs_a", i), outs_a, want_outs(vecs[i].exp_a));
            check($sformatf("row%0d_state_b", i), dbg_b, vecs[i].exp_b);
            check($sformatf("row%0d_outs_b", i), outs_b, want_outs(vecs[i].exp_b));
            @(negedge clock_50);
        end

        // Asynchronous reset while both instances are in PLAY
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_state_a", dbg_a, 0);
        check("async_rst_outs_a", outs_a, 7'b1100001);
        check("async_rst_state_b", dbg_b, 0);
        check("async_rst_e2_b", e2_b, 1'b0);
        @(negedge clock_50);
        reset = 1'b0;
        @(posedge clock_50);
        #1;
        check("post_rst_state_a", dbg_a, 1);
        check("post_rst_e1_a", e1_a, 1'b1);
        check("post_rst_state_b", dbg_b, 1);

        // Randomized play against the reference model
        @(negedge clock_50);
        reset = 1'b1;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clock_50);
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) key = ~key;
            end_fpga = ($urandom_range(0, 3) == 0);
            end_user = ($urandom_range(0, 4) == 0);
            end_time = ($urandom_range(0, 9) == 0);
            win      = ($urandom_range(0, 3) == 0);
            match    = ($urandom_range(0, 2) != 0);
            @(posedge clock_50);
            model_step();
            exp_q.push_back({m_state[0][2:0], want_outs(m_state[0])});
            exp_q.push_back({m_state[1][2:0], want_outs(m_state[1])});
            #1;
            exp_v = exp_q.pop_front();
            check($sformatf("rand%0d_a", c), {dbg_a, outs_a}, exp_v);
            exp_v = exp_q.pop_front();
            check($sformatf("rand%0d_b", c), {dbg_b, outs_b}, exp_v);
            @(negedge clock_50);
        end

        // Final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
